me_sad_search_param: RTL and testbench

//  Parametrised full-search SAD motion-estimation engine: BLK x BLK current block vs SR_X x SR_Y candidate window.

---
 rtl/me_pkg.sv | 32 +++
 rtl/me_sad_row.sv | 64 ++++++
 rtl/me_sad_search_param.sv | 184 ++++++++++++++++++
 tb/tb_me_sad_search_param.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/me_pkg.sv
// Shared definitions for the SAD motion-estimation engine.
//   - default geometry constants (pixel width, block edge, search range)
//   - search FSM state encoding
//   - constant clog2 helper used for derived widths
package me_pkg;

    localparam int unsigned PIX_W_DEF = 8;
    localparam int unsigned BLK_DEF   = 8;
    localparam int unsigned SR_X_DEF  = 16;
    localparam int unsigned SR_Y_DEF  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } me_state_e;

    // Smallest r with 2**r >= v.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned p;
        r = 0;
        p = 1;
        while (p < v) begin
            p = p << 1;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/me_sad_row.sv
// One horizontal candidate lane of the SAD engine.
//   load_i : capture |crt - ref| for all BLK pixels (stage 1)
//   crt_i  : current row, pixel 0 in MSBs
//   ref_i  : reference segment aligned to this candidate, pixel 0 in MSBs
//   add_i  : add the registered row of diffs into the accumulator (stage 2)
//   clr_i  : row being added is row 0, so restart the accumulator
//   acc_o  : running SAD for the current pass
module me_sad_row
    import me_pkg::*;
#(
    parameter int unsigned PIX_W = PIX_W_DEF,
    parameter int unsigned BLK   = BLK_DEF,
    parameter int unsigned SAD_W = PIX_W + clog2(BLK * BLK)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_i,
    input  logic [BLK*PIX_W-1:0] crt_i,
    input  logic [BLK*PIX_W-1:0] ref_i,
    input  logic                 add_i,
    input  logic                 clr_i,
    output logic [SAD_W-1:0]     acc_o
);

    logic [PIX_W-1:0] diff_d [BLK];
    logic [PIX_W-1:0] diff_q [BLK];
    logic [SAD_W-1:0] row_sum_c;
    logic [SAD_W-1:0] acc_q;

    // Per-pixel absolute difference.
    always_comb begin
        for (int p = 0; p < BLK; p++) begin
            if (crt_i[(BLK-1-p)*PIX_W +: PIX_W] > ref_i[(BLK-1-p)*PIX_W +: PIX_W])
                diff_d[p] = crt_i[(BLK-1-p)*PIX_W +: PIX_W] - ref_i[(BLK-1-p)*PIX_W +: PIX_W];
            else
                diff_d[p] = ref_i[(BLK-1-p)*PIX_W +: PIX_W] - crt_i[(BLK-1-p)*PIX_W +: PIX_W];
        end
    end

    // Row adder over the registered diffs.
    always_comb begin
        row_sum_c = '0;
        for (int p = 0; p < BLK; p++)
            row_sum_c = row_sum_c + SAD_W'(diff_q[p]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < BLK; p++)
                diff_q[p] <= '0;
            acc_q <= '0;
        end else begin
            if (load_i) begin
                for (int p = 0; p < BLK; p++)
                    diff_q[p] <= diff_d[p];
            end
            if (add_i)
                acc_q <= (clr_i ? '0 : acc_q) + row_sum_c;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/me_sad_search_param.sv
// Full-search SAD motion estimation: BLK x BLK block vs SR_X x SR_Y candidates.
//   in_valid/in_ready/in_first : row beat handshake, in_first starts a search
//   crt_row / ref_row          : current row and reference row segment
//   out_valid/out_ready        : result handshake, result held until taken
//   sad_min, mv_x, mv_y        : best SAD and signed offset from window centre
//   proto_err                  : pulse when a non-first beat arrives while idle
module me_sad_search_param
    import me_pkg::*;
#(
    parameter  int unsigned PIX_W = PIX_W_DEF,
    parameter  int unsigned BLK   = BLK_DEF,
    parameter  int unsigned SR_X  = SR_X_DEF,
    parameter  int unsigned SR_Y  = SR_Y_DEF,
    localparam int unsigned SAD_W = PIX_W + clog2(BLK * BLK),
    localparam int unsigned MVX_W = clog2(SR_X),
    localparam int unsigned MVY_W = clog2(SR_Y),
    localparam int unsigned NREF  = BLK + SR_X - 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_first,
    input  logic [BLK*PIX_W-1:0]  crt_row,
    input  logic [NREF*PIX_W-1:0] ref_row,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SAD_W-1:0]      sad_min,
    output logic [MVX_W-1:0]      mv_x,
    output logic [MVY_W-1:0]      mv_y,
    output logic                  proto_err
);

    localparam int unsigned      ROW_W     = clog2(BLK);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(BLK - 1);
    localparam logic [MVY_W-1:0] PASS_LAST = MVY_W'(SR_Y - 1);

    me_state_e        state_q;
    logic             in_ready_q, out_valid_q, proto_err_q;
    logic [ROW_W-1:0] row_q;
    logic [MVY_W-1:0] pass_q;
    logic             s1_v_q, s1_row0_q, s1_last_q;
    logic [MVY_W-1:0] s1_pass_q;
    logic             cmp_v_q;
    logic [MVY_W-1:0] cmp_pass_q;
    logic [SAD_W-1:0] min_q, sad_q;
    logic [MVX_W-1:0] bx_q, mvx_q;
    logic [MVY_W-1:0] by_q, mvy_q;

    logic             fire_d, take_d, start_d, beat_last_d;
    logic [ROW_W-1:0] beat_row_d;
    logic [MVY_W-1:0] beat_pass_d;
    logic [SAD_W-1:0] acc_c [SR_X];
    logic [SAD_W-1:0] best_sad_c;
    logic [MVX_W-1:0] best_x_c;
    logic [MVY_W-1:0] best_y_c;

    // A beat with in_first is always row 0 of pass 0, whatever the counters say.
    assign fire_d      = in_valid && in_ready_q;
    assign start_d     = fire_d && in_first;
    assign take_d      = fire_d && (in_first || (state_q == ACCUM));
    assign beat_row_d  = in_first ? '0 : row_q;
    assign beat_pass_d = in_first ? '0 : pass_q;
    assign beat_last_d = (beat_row_d == ROW_LAST) && (beat_pass_d == PASS_LAST);

    // One lane per horizontal candidate; lane cx sees ref pixels cx..cx+BLK-1.
    for (genvar cx = 0; cx < SR_X; cx++) begin : g_row
        me_sad_row #(
            .PIX_W (PIX_W),
            .BLK   (BLK),
            .SAD_W (SAD_W)
        ) u_row (
            .clk    (clk),
            .rst    (rst),
            .load_i (take_d),
            .crt_i  (crt_row),
            .ref_i  (ref_row[(NREF-BLK-cx)*PIX_W +: BLK*PIX_W]),
            .add_i  (s1_v_q),
            .clr_i  (s1_row0_q),
            .acc_o  (acc_c[cx])
        );
    end

    // Ascending cx scan with strict less-than keeps the earliest candidate on ties.
    always_comb begin
        best_sad_c = min_q;
        best_x_c   = bx_q;
        best_y_c   = by_q;
        for (int cx = 0; cx < SR_X; cx++) begin
            if (acc_c[cx] < best_sad_c) begin
                best_sad_c = acc_c[cx];
                best_x_c   = MVX_W'(cx);
                best_y_c   = cmp_pass_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            proto_err_q <= 1'b0;
            row_q       <= '0;
            pass_q      <= '0;
            s1_v_q      <= 1'b0;
            s1_row0_q   <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_pass_q   <= '0;
            cmp_v_q     <= 1'b0;
            cmp_pass_q  <= '0;
            min_q       <= '1;
            bx_q        <= '0;
            by_q        <= '0;
            sad_q       <= '1;
            mvx_q       <= '0;
            mvy_q       <= '0;
        end else begin
            proto_err_q <= fire_d && !in_first && (state_q == IDLE);
            s1_v_q      <= take_d;
            // A restart discards any pass result still in flight from the old search.
            cmp_v_q     <= s1_v_q && s1_last_q && !start_d;
            cmp_pass_q  <= s1_pass_q;

            if (take_d) begin
                s1_row0_q <= (beat_row_d == '0);
                s1_last_q <= (beat_row_d == ROW_LAST);
                s1_pass_q <= beat_pass_d;
                if (beat_row_d == ROW_LAST) begin
                    row_q  <= '0;
                    pass_q <= beat_pass_d + MVY_W'(1);
                end else begin
                    row_q  <= beat_row_d + ROW_W'(1);
                    pass_q <= beat_pass_d;
                end
                if (beat_last_d) begin
                    state_q    <= DRAIN;
                    in_ready_q <= 1'b0;
                end else begin
                    state_q <= ACCUM;
                end
            end

            if (cmp_v_q) begin
                min_q <= best_sad_c;
                bx_q  <= best_x_c;
                by_q  <= best_y_c;
            end
            if (start_d) begin
                min_q <= '1;
                bx_q  <= '0;
                by_q  <= '0;
            end

            case (state_q)
                DRAIN: begin
                    if (!s1_v_q && !cmp_v_q) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        sad_q       <= min_q;
                        mvx_q       <= bx_q - MVX_W'(SR_X / 2);
                        mvy_q       <= by_q - MVY_W'(SR_Y / 2);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign proto_err = proto_err_q;
    assign sad_min   = sad_q;
    assign mv_x      = mvx_q;
    assign mv_y      = mvy_q;

endmodule

// File: tb/tb_me_sad_search_param.sv
// Self-checking bench for me_sad_search_param at default geometry.
module tb_me_sad_search_param;

    localparam int BLK  = 8;
    localparam int SRX  = 16;
    localparam int SRY  = 16;
    localparam int NREF = BLK + SRX - 1;
    localparam int NRY  = BLK + SRY - 1;
    localparam int NBEAT = BLK * SRY;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_first = 1'b0;
    logic              out_ready = 1'b1;
    logic              in_ready, out_valid, proto_err;
    logic [BLK*8-1:0]  crt_row = '0;
    logic [NREF*8-1:0] ref_row = '0;
    logic [13:0]       sad_min;
    logic [3:0]        mv_x, mv_y;

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0] crt_m [BLK][BLK];
    logic [7:0] ref_m [NRY][NREF];
    int         exp_sad;
    logic [3:0] exp_x, exp_y;

    always #5 clk = ~clk;

    me_sad_search_param dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_first  (in_first),
        .crt_row   (crt_row),
        .ref_row   (ref_row),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sad_min   (sad_min),
        .mv_x      (mv_x),
        .mv_y      (mv_y),
        .proto_err (proto_err)
    );

    // Reference: exhaustive SAD over the window, scan cy then cx, strict less-than.
    task automatic compute_model();
        int best, bx, by, s, d;
        best = 1 << 30; bx = 0; by = 0;
        for (int cy = 0; cy < SRY; cy++)
            for (int cx = 0; cx < SRX; cx++) begin
                s = 0;
                for (int r = 0; r < BLK; r++)
                    for (int p = 0; p < BLK; p++) begin
                        d = int'(crt_m[r][p]) - int'(ref_m[cy+r][cx+p]);
                        s += (d < 0) ? -d : d;
                    end
                if (s < best) begin best = s; bx = cx; by = cy; end
            end
        exp_sad = best;
        exp_x   = 4'(bx - SRX / 2);
        exp_y   = 4'(by - SRY / 2);
    endtask

    task automatic fill_const(input logic [7:0] c, input logic [7:0] rv);
        for (int r = 0; r < BLK; r++) for (int p = 0; p < BLK; p++) crt_m[r][p] = c;
        for (int y = 0; y < NRY; y++) for (int x = 0; x < NREF; x++) ref_m[y][x] = rv;
    endtask

    task automatic fill_random();
        for (int r = 0; r < BLK; r++) for (int p = 0; p < BLK; p++) crt_m[r][p] = 8'($urandom);
        for (int y = 0; y < NRY; y++) for (int x = 0; x < NREF; x++) ref_m[y][x] = 8'($urandom);
    endtask

    // Beats 0..n-1 of a search (beat b = pass b/BLK, row b%BLK), in_first on beat 0.
    task automatic drive_beats(input int n, input int gap_pct);
        int cy, r;
        for (int b = 0; b < n; b++) begin
            while ($urandom_range(99) < gap_pct) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            cy = b / BLK;
            r  = b % BLK;
            for (int p = 0; p < BLK; p++) crt_row[(BLK-1-p)*8 +: 8] = crt_m[r][p];
            for (int i = 0; i < NREF; i++) ref_row[(NREF-1-i)*8 +: 8] = ref_m[cy+r][i];
            in_valid = 1'b1;
            in_first = (b == 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_first = 1'b0;
    endtask

    task automatic wait_result(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_chk++; if (sad_min !== 14'h3FFF) begin n_fail++; $display("FAIL reset_sad got %h want 3fff", sad_min); end
        n_chk++; if (mv_x !== 4'h0 || mv_y !== 4'h0) begin n_fail++; $display("FAIL reset_mv got %h,%h want 0,0", mv_x, mv_y); end
        n_chk++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL reset_proto_err got %b want 0", proto_err); end
    endtask

    task automatic test_zero();
        int cyc;
        fill_const(8'h00, 8'h00);
        drive_beats(NBEAT, 0);
        wait_result(cyc);
        n_chk++; if (cyc !== 3) begin n_fail++; $display("FAIL zero_latency got %0d want 3", cyc); end
        n_chk++; if (sad_min !== 14'd0) begin n_fail++; $display("FAIL zero_sad got %0d want 0", sad_min); end
        n_chk++; if (mv_x !== 4'h8 || mv_y !== 4'h8) begin n_fail++; $display("FAIL zero_mv got %h,%h want 8,8", mv_x, mv_y); end
        @(posedge clk); #1;
        n_chk++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL zero_handshake got ov=%b ir=%b want 0,1", out_valid, in_ready); end
    endtask

    task automatic test_match();
        int cyc;
        fill_random();
        for (int r = 0; r < BLK; r++) for (int p = 0; p < BLK; p++) ref_m[5+r][11+p] = crt_m[r][p];
        compute_model();
        drive_beats(NBEAT, 0);
        wait_result(cyc);
        n_chk++; if (cyc !== 3) begin n_fail++; $display("FAIL match_latency got %0d want 3", cyc); end
        n_chk++; if (sad_min !== 14'd0) begin n_fail++; $display("FAIL match_sad got %0d want 0", sad_min); end
        n_chk++; if (mv_x !== 4'h3 || mv_y !== 4'hD) begin n_fail++; $display("FAIL match_mv got %h,%h want 3,d", mv_x, mv_y); end
        n_chk++; if (sad_min !== 14'(exp_sad) || mv_x !== exp_x || mv_y !== exp_y) begin
            n_fail++; $display("FAIL match_model got %0d,%h,%h want %0d,%h,%h", sad_min, mv_x, mv_y, exp_sad, exp_x, exp_y); end
        @(posedge clk); #1;
    endtask

    task automatic test_max();
        int cyc;
        fill_const(8'hFF, 8'h00);
        drive_beats(NBEAT, 0);
        wait_result(cyc);
        n_chk++; if (cyc !== 3) begin n_fail++; $display("FAIL max_latency got %0d want 3", cyc); end
        n_chk++; if (sad_min !== 14'h3FC0) begin n_fail++; $display("FAIL max_sad got %h want 3fc0", sad_min); end
        n_chk++; if (mv_x !== 4'h8 || mv_y !== 4'h8) begin n_fail++; $display("FAIL max_mv got %h,%h want 8,8", mv_x, mv_y); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int cyc;
        fill_random();
        compute_model();
        out_ready = 1'b0;
        drive_beats(NBEAT, 50);
        wait_result(cyc);
        n_chk++; if (cyc !== 3) begin n_fail++; $display("FAIL bp_latency got %0d want 3", cyc); end
        for (int i = 0; i < 20; i++) begin
            // Offer a new search while the result is pending; it must not be taken.
            in_valid = 1'b1;
            in_first = 1'b1;
            @(posedge clk); #1;
            n_chk++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                n_fail++; $display("FAIL bp_hold_%0d got ov=%b ir=%b want 1,0", i, out_valid, in_ready); end
            n_chk++; if (sad_min !== 14'(exp_sad) || mv_x !== exp_x || mv_y !== exp_y) begin
                n_fail++; $display("FAIL bp_result_%0d got %0d,%h,%h want %0d,%h,%h", i, sad_min, mv_x, mv_y, exp_sad, exp_x, exp_y); end
        end
        in_valid = 1'b0;
        in_first = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_chk++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release got ov=%b ir=%b want 0,1", out_valid, in_ready); end
    endtask

    task automatic test_abort_proto();
        int cyc;
        fill_random();
        drive_beats(7 * BLK + 3, 0);
        fill_random();
        compute_model();
        drive_beats(NBEAT, 0);
        wait_result(cyc);
        n_chk++; if (cyc !== 3) begin n_fail++; $display("FAIL abort_latency got %0d want 3", cyc); end
        n_chk++; if (sad_min !== 14'(exp_sad) || mv_x !== exp_x || mv_y !== exp_y) begin
            n_fail++; $display("FAIL abort_model got %0d,%h,%h want %0d,%h,%h", sad_min, mv_x, mv_y, exp_sad, exp_x, exp_y); end
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_first = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_chk++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL proto_pulse got %b want 1", proto_err); end
        @(posedge clk); #1;
        n_chk++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL proto_one_cycle got %b want 0", proto_err); end
        n_chk++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL proto_idle got ir=%b ov=%b want 1,0", in_ready, out_valid); end
    endtask

    task automatic test_rst_midway();
        int cyc;
        fill_random();
        drive_beats(40, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        n_chk++; if (out_valid !== 1'b0 || sad_min !== 14'h3FFF || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL rst_accum got ov=%b sad=%h ir=%b want 0,3fff,1", out_valid, sad_min, in_ready); end
        rst = 1'b0;
        fill_random();
        compute_model();
        drive_beats(NBEAT, 20);
        wait_result(cyc);
        n_chk++; if (sad_min !== 14'(exp_sad) || mv_x !== exp_x || mv_y !== exp_y) begin
            n_fail++; $display("FAIL rst_accum_after got %0d,%h,%h want %0d,%h,%h", sad_min, mv_x, mv_y, exp_sad, exp_x, exp_y); end
        @(posedge clk); #1;
        out_ready = 1'b0;
        drive_beats(NBEAT, 0);
        wait_result(cyc);
        n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_done_pre got %b want 1", out_valid); end
        rst = 1'b1;
        @(posedge clk); #1;
        n_chk++; if (out_valid !== 1'b0 || sad_min !== 14'h3FFF || mv_x !== 4'h0 || mv_y !== 4'h0) begin
            n_fail++; $display("FAIL rst_done got ov=%b sad=%h mv=%h,%h want 0,3fff,0,0", out_valid, sad_min, mv_x, mv_y); end
        rst = 1'b0;
        out_ready = 1'b1;
        fill_random();
        compute_model();
        drive_beats(NBEAT, 30);
        wait_result(cyc);
        n_chk++; if (cyc !== 3) begin n_fail++; $display("FAIL rst_done_latency got %0d want 3", cyc); end
        n_chk++; if (sad_min !== 14'(exp_sad) || mv_x !== exp_x || mv_y !== exp_y) begin
            n_fail++; $display("FAIL rst_done_after got %0d,%h,%h want %0d,%h,%h", sad_min, mv_x, mv_y, exp_sad, exp_x, exp_y); end
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        test_zero();
        test_match();
        test_max();
        test_backpressure();
        test_abort_proto();
        test_rst_midway();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
